// File: rtl/axi_llc_arcane_pkg.sv
// Shared types and constants for the ARCANE lock request path.
package axi_llc_arcane_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FLUSH = 2'd1,
      REQ        = 2'd2,
      ERR        = 2'd3
   } lock_req_state_e;

   localparam int unsigned DefaultLockTimeout = 1024;

endpackage

// File: rtl/axi_llc_arcane_lock_req.sv
// eCPU lock/unlock write front-end: filters redundant writes, defers behind flush,
// issues req to the lock FSM, owns the architectural lock bit and a timeout error.
module axi_llc_arcane_lock_req
   import axi_llc_arcane_pkg::*;
#(
   parameter int unsigned TimeoutCycles = DefaultLockTimeout
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic lock_wr_valid_i,
   input  logic lock_wr_value_i,
   output logic lock_wr_ready_o,
   input  logic flush_busy_i,
   output logic ecpu_lock_o,
   output logic ecpu_lock_req_o,
   input  logic ready_lock_i,
   output logic lock_done_o,
   output logic lock_pending_o,
   output logic lock_err_o,
   input  logic lock_err_clr_i
);

   // Width kept at least 1 so the counter stays legal when the timeout is disabled.
   localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntWidth-1:0] CntLast =
      (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;
   localparam logic [CntWidth-1:0] CntMax = '1;

   lock_req_state_e     state_q;
   logic                target_q;
   logic                lock_q;
   logic                req_q;
   logic                done_q;
   logic                err_q;
   logic [CntWidth-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         target_q <= 1'b0;
         lock_q   <= 1'b0;
         req_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (lock_wr_valid_i) begin
                  if (lock_wr_value_i == lock_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q <= lock_wr_value_i;
                     cnt_q    <= '0;
                     if (flush_busy_i) begin
                        state_q <= WAIT_FLUSH;
                     end else begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                     end
                  end
               end
            end
            WAIT_FLUSH: begin
               if (!flush_busy_i) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            REQ: begin
               // A grant on the final timeout cycle takes priority over the error.
               if (ready_lock_i) begin
                  lock_q  <= target_q;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if ((TimeoutCycles > 0) && (cnt_q == CntLast)) begin
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ERR: begin
               if (lock_err_clr_i) begin
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lock_wr_ready_o = (state_q == IDLE);
   assign lock_pending_o  = (state_q == WAIT_FLUSH) || (state_q == REQ);
   assign ecpu_lock_o     = lock_q;
   assign ecpu_lock_req_o = req_q;
   assign lock_done_o     = done_q;
   assign lock_err_o      = err_q;

endmodule

// File: tb/tb_axi_llc_arcane_lock_req.sv
// Directed bench for axi_llc_arcane_lock_req with an 8-cycle timeout.
module tb_axi_llc_arcane_lock_req;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic lock_wr_valid_i = 1'b0;
   logic lock_wr_value_i = 1'b0;
   logic lock_wr_ready_o;
   logic flush_busy_i = 1'b0;
   logic ecpu_lock_o;
   logic ecpu_lock_req_o;
   logic ready_lock_i = 1'b0;
   logic lock_done_o;
   logic lock_pending_o;
   logic lock_err_o;
   logic lock_err_clr_i = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk_i = ~clk_i;

   axi_llc_arcane_lock_req #(.TimeoutCycles(8)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .lock_wr_valid_i (lock_wr_valid_i),
      .lock_wr_value_i (lock_wr_value_i),
      .lock_wr_ready_o (lock_wr_ready_o),
      .flush_busy_i    (flush_busy_i),
      .ecpu_lock_o     (ecpu_lock_o),
      .ecpu_lock_req_o (ecpu_lock_req_o),
      .ready_lock_i    (ready_lock_i),
      .lock_done_o     (lock_done_o),
      .lock_pending_o  (lock_pending_o),
      .lock_err_o      (lock_err_o),
      .lock_err_clr_i  (lock_err_clr_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // reset
      #2;
      chk("rst_lock", 32'(ecpu_lock_o), 32'd0);
      chk("rst_req", 32'(ecpu_lock_req_o), 32'd0);
      chk("rst_done", 32'(lock_done_o), 32'd0);
      chk("rst_err", 32'(lock_err_o), 32'd0);
      chk("rst_pend", 32'(lock_pending_o), 32'd0);
      chk("rst_wrrdy", 32'(lock_wr_ready_o), 32'd1);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // acquire: grant three cycles after req rises
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b1;
      step();
      lock_wr_valid_i = 1'b0;
      chk("acq_req0", 32'(ecpu_lock_req_o), 32'd1);
      chk("acq_pend", 32'(lock_pending_o), 32'd1);
      chk("acq_wrrdy", 32'(lock_wr_ready_o), 32'd0);
      chk("acq_lock0", 32'(ecpu_lock_o), 32'd0);
      step();
      chk("acq_req1", 32'(ecpu_lock_req_o), 32'd1);
      step();
      chk("acq_req2", 32'(ecpu_lock_req_o), 32'd1);
      ready_lock_i = 1'b1;
      step();
      ready_lock_i = 1'b0;
      chk("acq_req_drop", 32'(ecpu_lock_req_o), 32'd0);
      chk("acq_lock", 32'(ecpu_lock_o), 32'd1);
      chk("acq_done", 32'(lock_done_o), 32'd1);
      chk("acq_wrrdy2", 32'(lock_wr_ready_o), 32'd1);
      chk("acq_pend2", 32'(lock_pending_o), 32'd0);
      step();
      chk("acq_done_end", 32'(lock_done_o), 32'd0);

      // redundant write
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b1;
      step();
      lock_wr_valid_i = 1'b0;
      chk("red_done", 32'(lock_done_o), 32'd1);
      chk("red_req", 32'(ecpu_lock_req_o), 32'd0);
      chk("red_lock", 32'(ecpu_lock_o), 32'd1);
      chk("red_pend", 32'(lock_pending_o), 32'd0);
      step();
      chk("red_done_end", 32'(lock_done_o), 32'd0);
      chk("red_req2", 32'(ecpu_lock_req_o), 32'd0);

      // release with ready already high
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b0; ready_lock_i = 1'b1;
      step();
      lock_wr_valid_i = 1'b0;
      chk("rel_req", 32'(ecpu_lock_req_o), 32'd1);
      chk("rel_lock_hold", 32'(ecpu_lock_o), 32'd1);
      step();
      ready_lock_i = 1'b0;
      chk("rel_req_drop", 32'(ecpu_lock_req_o), 32'd0);
      chk("rel_lock", 32'(ecpu_lock_o), 32'd0);
      chk("rel_done", 32'(lock_done_o), 32'd1);
      chk("rel_idle", 32'(lock_wr_ready_o), 32'd1);

      // flush collision: flush held 10 cycles
      flush_busy_i = 1'b1; lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b1;
      step();
      lock_wr_valid_i = 1'b0;
      chk("fl_pend0", 32'(lock_pending_o), 32'd1);
      chk("fl_req0", 32'(ecpu_lock_req_o), 32'd0);
      for (int i = 1; i < 10; i++) begin
         step();
         chk($sformatf("fl_pend%0d", i), 32'(lock_pending_o), 32'd1);
         chk($sformatf("fl_req%0d", i), 32'(ecpu_lock_req_o), 32'd0);
      end
      flush_busy_i = 1'b0;
      step();
      chk("fl_req_rise", 32'(ecpu_lock_req_o), 32'd1);
      chk("fl_pend_req", 32'(lock_pending_o), 32'd1);
      ready_lock_i = 1'b1;
      step();
      ready_lock_i = 1'b0;
      chk("fl_lock", 32'(ecpu_lock_o), 32'd1);
      chk("fl_done", 32'(lock_done_o), 32'd1);

      // timeout: no grant for 8 req cycles
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b0;
      step();
      lock_wr_valid_i = 1'b0;
      chk("to_req0", 32'(ecpu_lock_req_o), 32'd1);
      for (int k = 1; k < 8; k++) begin
         step();
         chk($sformatf("to_req%0d", k), 32'(ecpu_lock_req_o), 32'd1);
         chk($sformatf("to_err%0d", k), 32'(lock_err_o), 32'd0);
      end
      step();
      chk("to_req_drop", 32'(ecpu_lock_req_o), 32'd0);
      chk("to_err", 32'(lock_err_o), 32'd1);
      chk("to_lock", 32'(ecpu_lock_o), 32'd1);
      chk("to_wrrdy", 32'(lock_wr_ready_o), 32'd0);
      chk("to_pend", 32'(lock_pending_o), 32'd0);
      ready_lock_i = 1'b1;
      step();
      ready_lock_i = 1'b0;
      chk("err_ign_rdy", 32'(lock_err_o), 32'd1);
      chk("err_ign_lock", 32'(ecpu_lock_o), 32'd1);
      lock_err_clr_i = 1'b1;
      step();
      lock_err_clr_i = 1'b0;
      chk("clr_err", 32'(lock_err_o), 32'd0);
      chk("clr_wrrdy", 32'(lock_wr_ready_o), 32'd1);
      chk("clr_lock", 32'(ecpu_lock_o), 32'd1);

      // grant on the last timeout cycle wins
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b0;
      step();
      lock_wr_valid_i = 1'b0;
      for (int k = 1; k < 8; k++) step();
      chk("edge_req", 32'(ecpu_lock_req_o), 32'd1);
      ready_lock_i = 1'b1;
      step();
      ready_lock_i = 1'b0;
      chk("edge_err", 32'(lock_err_o), 32'd0);
      chk("edge_lock", 32'(ecpu_lock_o), 32'd0);
      chk("edge_done", 32'(lock_done_o), 32'd1);

      // reset during REQ
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b1;
      step();
      lock_wr_valid_i = 1'b0;
      ready_lock_i = 1'b1;
      step();
      ready_lock_i = 1'b0;
      chk("rr_lock1", 32'(ecpu_lock_o), 32'd1);
      lock_wr_valid_i = 1'b1; lock_wr_value_i = 1'b0;
      step();
      lock_wr_valid_i = 1'b0;
      chk("rr_req", 32'(ecpu_lock_req_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rr_req0", 32'(ecpu_lock_req_o), 32'd0);
      chk("rr_lock0", 32'(ecpu_lock_o), 32'd0);
      chk("rr_err0", 32'(lock_err_o), 32'd0);
      chk("rr_pend0", 32'(lock_pending_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      chk("rr_wrrdy", 32'(lock_wr_ready_o), 32'd1);
      chk("rr_req_after", 32'(ecpu_lock_req_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
